// File: rtl/i2c_reg_pkg.sv
// Shared types and constants for the I2C register access front end.
package i2c_reg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD_WR,
      DATA,
      CMD_RD,
      RD_DATA,
      WAIT_IDLE,
      RESP
   } state_t;

   localparam int CNT_W = 2;
   localparam logic [7:0] IDLE_RDATA = 8'h00;

endpackage

// File: rtl/i2c_reg_access.sv
// Register read/write sequencer feeding i2c_master command/data streams.
// Optional watchdog enabled by defining I2C_REG_TIMEOUT_EN.
module i2c_reg_access
   import i2c_reg_pkg::*;
#(
   parameter int REG_ADDR_BYTES = 1,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_read,
   input  logic [6:0]                  req_dev_addr,
   input  logic [8*REG_ADDR_BYTES-1:0] req_reg_addr,
   input  logic [7:0]                  req_wdata,
   output logic                        rsp_valid,
   output logic [7:0]                  rsp_rdata,
   output logic                        rsp_err,
   output logic [6:0]                  m_axis_cmd_address,
   output logic                        m_axis_cmd_start,
   output logic                        m_axis_cmd_read,
   output logic                        m_axis_cmd_write,
   output logic                        m_axis_cmd_write_multiple,
   output logic                        m_axis_cmd_stop,
   output logic                        m_axis_cmd_valid,
   input  logic                        m_axis_cmd_ready,
   output logic [7:0]                  m_axis_data_tdata,
   output logic                        m_axis_data_tvalid,
   input  logic                        m_axis_data_tready,
   output logic                        m_axis_data_tlast,
   input  logic [7:0]                  s_axis_data_tdata,
   input  logic                        s_axis_data_tvalid,
   output logic                        s_axis_data_tready,
   input  logic                        s_axis_data_tlast,
   input  logic                        i2c_busy,
   input  logic                        i2c_missed_ack
);

   localparam int SH_W = 8 * (REG_ADDR_BYTES + 1);

   state_t                      state;
   logic                        rd_q;
   logic [8*REG_ADDR_BYTES-1:0] ra_q;
   logic [7:0]                  wd_q;
   logic                        err;
   logic                        busy_seen;
   logic [CNT_W-1:0]            bcnt;
   logic [CNT_W-1:0]            nxt;
   logic [CNT_W-1:0]            last;
   logic                        unused;

   assign nxt = bcnt + CNT_W'(1);
   assign last = rd_q ? CNT_W'(REG_ADDR_BYTES - 1)
                      : CNT_W'(REG_ADDR_BYTES);
   assign unused = ^{s_axis_data_tlast, 32'(TIMEOUT_CYCLES)};

   // Byte i of the stream {reg addr MSB first, wdata}.
   function automatic logic [7:0] pick(input logic [CNT_W-1:0] i);
      logic [SH_W-1:0] sh;
      sh = {ra_q, wd_q} << {i, 3'b000};
      return sh[SH_W-1 -: 8];
   endfunction

`ifdef I2C_REG_TIMEOUT_EN
   logic [31:0] wd;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state                     <= IDLE;
         req_ready                 <= 1'b0;
         rd_q                      <= 1'b0;
         ra_q                      <= '0;
         wd_q                      <= '0;
         err                       <= 1'b0;
         busy_seen                 <= 1'b0;
         bcnt                      <= '0;
         rsp_valid                 <= 1'b0;
         rsp_rdata                 <= IDLE_RDATA;
         rsp_err                   <= 1'b0;
         m_axis_cmd_address        <= '0;
         m_axis_cmd_start          <= 1'b0;
         m_axis_cmd_read           <= 1'b0;
         m_axis_cmd_write          <= 1'b0;
         m_axis_cmd_write_multiple <= 1'b0;
         m_axis_cmd_stop           <= 1'b0;
         m_axis_cmd_valid          <= 1'b0;
         m_axis_data_tdata         <= '0;
         m_axis_data_tvalid        <= 1'b0;
         m_axis_data_tlast         <= 1'b0;
         s_axis_data_tready        <= 1'b0;
`ifdef I2C_REG_TIMEOUT_EN
         wd                        <= '0;
`endif
      end else begin
         if (state != IDLE && i2c_missed_ack)
            err <= 1'b1;
         // Busy before the first command handshake may be stale.
         if (state != IDLE && state != CMD_WR && i2c_busy)
            busy_seen <= 1'b1;

         unique case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready                 <= 1'b0;
                  rd_q                      <= req_read;
                  ra_q                      <= req_reg_addr;
                  wd_q                      <= req_wdata;
                  err                       <= 1'b0;
                  busy_seen                 <= 1'b0;
                  bcnt                      <= '0;
                  rsp_rdata                 <= IDLE_RDATA;
                  m_axis_cmd_address        <= req_dev_addr;
                  m_axis_cmd_write_multiple <= 1'b1;
                  m_axis_cmd_stop           <= !req_read;
                  m_axis_cmd_valid          <= 1'b1;
                  state                     <= CMD_WR;
               end
            end
            CMD_WR: begin
               if (m_axis_cmd_ready) begin
                  m_axis_cmd_valid          <= 1'b0;
                  m_axis_cmd_write_multiple <= 1'b0;
                  m_axis_cmd_stop           <= 1'b0;
                  m_axis_data_tdata         <= pick('0);
                  m_axis_data_tlast         <= (last == '0);
                  m_axis_data_tvalid        <= 1'b1;
                  bcnt                      <= '0;
                  state                     <= DATA;
               end
            end
            DATA: begin
               if (m_axis_data_tready) begin
                  if (bcnt == last) begin
                     m_axis_data_tvalid <= 1'b0;
                     m_axis_data_tlast  <= 1'b0;
                     if (rd_q) begin
                        m_axis_cmd_start <= 1'b1;
                        m_axis_cmd_read  <= 1'b1;
                        m_axis_cmd_stop  <= 1'b1;
                        m_axis_cmd_valid <= 1'b1;
                        state            <= CMD_RD;
                     end else begin
                        state <= WAIT_IDLE;
                     end
                  end else begin
                     bcnt              <= nxt;
                     m_axis_data_tdata <= pick(nxt);
                     m_axis_data_tlast <= (nxt == last);
                  end
               end
            end
            CMD_RD: begin
               if (m_axis_cmd_ready) begin
                  m_axis_cmd_valid   <= 1'b0;
                  m_axis_cmd_start   <= 1'b0;
                  m_axis_cmd_read    <= 1'b0;
                  m_axis_cmd_stop    <= 1'b0;
                  s_axis_data_tready <= 1'b1;
                  state              <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (s_axis_data_tvalid) begin
                  rsp_rdata          <= s_axis_data_tdata;
                  s_axis_data_tready <= 1'b0;
                  state              <= WAIT_IDLE;
               end
            end
            WAIT_IDLE: begin
               if (busy_seen && !i2c_busy) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= err | i2c_missed_ack;
                  state     <= RESP;
               end
            end
            RESP: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase

`ifdef I2C_REG_TIMEOUT_EN
         // Watchdog overrides whatever the sequencer chose this cycle.
         if (state == IDLE) begin
            wd <= '0;
         end else if (state != RESP) begin
            if (wd == 32'(TIMEOUT_CYCLES)) begin
               m_axis_cmd_valid          <= 1'b0;
               m_axis_cmd_start          <= 1'b0;
               m_axis_cmd_read           <= 1'b0;
               m_axis_cmd_write          <= 1'b0;
               m_axis_cmd_write_multiple <= 1'b0;
               m_axis_cmd_stop           <= 1'b0;
               m_axis_data_tvalid        <= 1'b0;
               m_axis_data_tlast         <= 1'b0;
               s_axis_data_tready        <= 1'b0;
               err                       <= 1'b1;
               rsp_valid                 <= 1'b1;
               rsp_err                   <= 1'b1;
               rsp_rdata                 <= IDLE_RDATA;
               state                     <= RESP;
            end else begin
               wd <= wd + 32'd1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_i2c_reg_access.sv
// Directed bench for i2c_reg_access: one instance per register address width.
module tb_i2c_reg_access;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic        req_valid [2];
   logic        req_read  [2];
   logic [6:0]  dev       [2];
   logic [15:0] ra        [2];
   logic [7:0]  wd        [2];
   logic        c_ready   [2];
   logic        d_tready  [2];
   logic [7:0]  s_tdata   [2];
   logic        s_tvalid  [2];
   logic        s_tlast   [2];
   logic        busy      [2];
   logic        mack      [2];

   wire         req_ready [2];
   wire         rsp_valid [2];
   wire [7:0]   rsp_rdata [2];
   wire         rsp_err   [2];
   wire [6:0]   c_addr    [2];
   wire         c_start   [2];
   wire         c_read    [2];
   wire         c_write   [2];
   wire         c_wm      [2];
   wire         c_stop    [2];
   wire         c_valid   [2];
   wire [7:0]   d_tdata   [2];
   wire         d_tvalid  [2];
   wire         d_tlast   [2];
   wire         s_tready  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      i2c_reg_access #(
         .REG_ADDR_BYTES(g + 1),
         .TIMEOUT_CYCLES(100)
      ) dut (
         .clk                       (clk),
         .rst                       (rst),
         .req_valid                 (req_valid[g]),
         .req_ready                 (req_ready[g]),
         .req_read                  (req_read[g]),
         .req_dev_addr              (dev[g]),
         .req_reg_addr              (ra[g][8*(g+1)-1:0]),
         .req_wdata                 (wd[g]),
         .rsp_valid                 (rsp_valid[g]),
         .rsp_rdata                 (rsp_rdata[g]),
         .rsp_err                   (rsp_err[g]),
         .m_axis_cmd_address        (c_addr[g]),
         .m_axis_cmd_start          (c_start[g]),
         .m_axis_cmd_read           (c_read[g]),
         .m_axis_cmd_write          (c_write[g]),
         .m_axis_cmd_write_multiple (c_wm[g]),
         .m_axis_cmd_stop           (c_stop[g]),
         .m_axis_cmd_valid          (c_valid[g]),
         .m_axis_cmd_ready          (c_ready[g]),
         .m_axis_data_tdata         (d_tdata[g]),
         .m_axis_data_tvalid        (d_tvalid[g]),
         .m_axis_data_tready        (d_tready[g]),
         .m_axis_data_tlast         (d_tlast[g]),
         .s_axis_data_tdata         (s_tdata[g]),
         .s_axis_data_tvalid        (s_tvalid[g]),
         .s_axis_data_tready        (s_tready[g]),
         .s_axis_data_tlast         (s_tlast[g]),
         .i2c_busy                  (busy[g]),
         .i2c_missed_ack            (mack[g])
      );
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [12:0] cmd_bus(input int d);
      return {c_valid[d], c_addr[d], c_start[d], c_read[d],
              c_write[d], c_wm[d], c_stop[d]};
   endfunction

   // One register transaction with the bench acting as i2c_master.
   task automatic xact(input int d, input logic rd,
                       input logic [6:0] dv, input logic [15:0] a,
                       input logic [7:0] w, input int stall,
                       input logic nack, input logic [7:0] slv,
                       input int rst_at);
      int n;
      int nb;
      int rab;
      logic [7:0] eb;
      logic [12:0] ewr;
      logic [12:0] erd;
      rab = d + 1;
      nb  = rd ? rab : rab + 1;
      ewr = {1'b1, dv, 1'b0, 1'b0, 1'b0, 1'b1, ~rd};
      erd = {1'b1, dv, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      n = 0;
      while (!req_ready[d] && n < 20) begin step; n++; end
      chk("req_ready", 16'(req_ready[d]), 16'd1);
      req_valid[d] = 1'b1;
      req_read[d]  = rd;
      dev[d]       = dv;
      ra[d]        = a;
      wd[d]        = w;
      step;
      req_valid[d] = 1'b0;
      chk("ready_drop", 16'(req_ready[d]), 16'd0);

      n = 0;
      while (!c_valid[d] && n < 20) begin step; n++; end
      chk("cmdwr", 16'(cmd_bus(d)), 16'(ewr));
      if (stall > 0) begin
         repeat (stall) step;
         chk("cmdwr_hold", 16'(cmd_bus(d)), 16'(ewr));
      end
      c_ready[d] = 1'b1;
      step;
      c_ready[d] = 1'b0;
      busy[d]    = 1'b1;

      for (int i = 0; i < nb; i++) begin
         eb = (i < rab) ? a[8*(rab-1-i) +: 8] : w;
         n = 0;
         while (!d_tvalid[d] && n < 20) begin step; n++; end
         chk("data_valid", 16'(d_tvalid[d]), 16'd1);
         if (i == 0 && stall > 0) begin
            chk("data_pre", 16'(d_tdata[d]), 16'(eb));
            repeat (stall) step;
         end
         chk("data_byte", 16'(d_tdata[d]), 16'(eb));
         chk("data_last", 16'(d_tlast[d]), 16'(i == nb - 1));
         if (i == rst_at) begin
            rst = 1'b1;
            step;
            rst     = 1'b0;
            busy[d] = 1'b0;
            chk("rst_valids",
                16'({c_valid[d], d_tvalid[d], s_tready[d],
                     rsp_valid[d]}), 16'd0);
            n = 0;
            repeat (6) begin
               if (rsp_valid[d]) n++;
               step;
            end
            chk("rst_no_rsp", 16'(n), 16'd0);
            return;
         end
         d_tready[d] = 1'b1;
         if (nack && i == 0) mack[d] = 1'b1;
         step;
         d_tready[d] = 1'b0;
         mack[d]     = 1'b0;
      end
      chk("data_done", 16'(d_tvalid[d]), 16'd0);

      if (rd) begin
         n = 0;
         while (!c_valid[d] && n < 20) begin step; n++; end
         chk("cmdrd", 16'(cmd_bus(d)), 16'(erd));
         c_ready[d] = 1'b1;
         step;
         c_ready[d] = 1'b0;
         chk("cmdrd_done", 16'(c_valid[d]), 16'd0);
         n = 0;
         while (!s_tready[d] && n < 20) begin step; n++; end
         chk("rd_tready", 16'(s_tready[d]), 16'd1);
         s_tvalid[d] = 1'b1;
         s_tdata[d]  = slv;
         s_tlast[d]  = 1'b1;
         step;
         s_tvalid[d] = 1'b0;
         s_tlast[d]  = 1'b0;
         chk("rd_tready_drop", 16'(s_tready[d]), 16'd0);
      end

      step;
      busy[d] = 1'b0;
      n = 0;
      while (!rsp_valid[d] && n < 20) begin step; n++; end
      chk("rsp_valid", 16'(rsp_valid[d]), 16'd1);
      chk("rsp_err", 16'(rsp_err[d]), 16'(nack));
      chk("rsp_rdata", 16'(rsp_rdata[d]), rd ? 16'(slv) : 16'h0);
      step;
      chk("rsp_pulse", 16'(rsp_valid[d]), 16'd0);
      chk("ready_back", 16'(req_ready[d]), 16'd1);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         req_read[d]  = 1'b0;
         dev[d]       = '0;
         ra[d]        = '0;
         wd[d]        = '0;
         c_ready[d]   = 1'b0;
         d_tready[d]  = 1'b0;
         s_tdata[d]   = '0;
         s_tvalid[d]  = 1'b0;
         s_tlast[d]   = 1'b0;
         busy[d]      = 1'b0;
         mack[d]      = 1'b0;
      end
      repeat (3) step;
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", 16'(req_ready[d]), 16'd0);
         chk("rst_cmd", 16'(cmd_bus(d)), 16'd0);
         chk("rst_out",
             16'({d_tvalid[d], d_tlast[d], s_tready[d],
                  rsp_valid[d], rsp_err[d]}), 16'd0);
         chk("rst_rdata", 16'(rsp_rdata[d]), 16'd0);
      end
      rst = 1'b0;

      xact(0, 1'b0, 7'h5a, 16'h0010, 8'hA5, 0, 1'b0, 8'h00, -1);
      xact(1, 1'b1, 7'h5a, 16'h0123, 8'h00, 0, 1'b0, 8'h3C, -1);
      xact(1, 1'b1, 7'h5a, 16'h0123, 8'h00, 7, 1'b0, 8'h3C, -1);
      xact(1, 1'b0, 7'h21, 16'hBEEF, 8'h77, 7, 1'b0, 8'h00, -1);
      xact(0, 1'b0, 7'h33, 16'h0044, 8'h55, 0, 1'b1, 8'h00, -1);
      xact(0, 1'b1, 7'h33, 16'h0044, 8'h00, 0, 1'b1, 8'h99, -1);
      xact(1, 1'b0, 7'h5a, 16'h0123, 8'hA5, 0, 1'b0, 8'h00, 1);
      xact(1, 1'b0, 7'h5a, 16'h0123, 8'hA5, 0, 1'b0, 8'h00, -1);
      xact(0, 1'b1, 7'h11, 16'h00FE, 8'h00, 0, 1'b0, 8'hC3, -1);

`ifdef I2C_REG_TIMEOUT_EN
      begin
         int n;
         n = 0;
         while (!req_ready[0] && n < 20) begin step; n++; end
         req_valid[0] = 1'b1;
         req_read[0]  = 1'b1;
         dev[0]       = 7'h42;
         ra[0]        = 16'h0007;
         step;
         req_valid[0] = 1'b0;
         n = 0;
         while (!rsp_valid[0] && n < 200) begin step; n++; end
         chk("to_cycles", 16'(n), 16'd101);
         chk("to_err", 16'(rsp_err[0]), 16'd1);
         chk("to_rdata", 16'(rsp_rdata[0]), 16'd0);
         chk("to_cmd", 16'(c_valid[0]), 16'd0);
         step;
         chk("to_ready", 16'(req_ready[0]), 16'd1);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/i2c_reg_access.md
Name: i2c_reg_access

Overview:
Register-level front end that sits directly upstream of i2c_master and drives its command and write-data streams. It also consumes i2c_master's read-data stream.
- Converts one register request into the correct I2C command/data sequence:
  - write: dev addr, reg addr bytes, data byte, with STOP;
  - read: dev addr, reg addr, repeated START, read 1 byte, STOP.
- Returns a single response carrying read data and an error flag taken from i2c_master's missed_ack.

Parameters:
REG_ADDR_BYTES, 1, register address width in bytes (legal 1 or 2); sent MSB first
TIMEOUT_CYCLES, 65535, watchdog limit in clk cycles per request (used only with I2C_REG_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&&req_ready
req_read  in  1  1=register read, 0=register write
req_dev_addr  in  7  I2C 7-bit device address
req_reg_addr  in  8*REG_ADDR_BYTES  register address
req_wdata  in  8  write data (ignored for read)
rsp_valid  out  1  response pulse, exactly 1 cycle
rsp_rdata  out  8  read data (0 for writes)
rsp_err  out  1  missed ACK or timeout occurred during request
m_axis_cmd_address  out  7  to i2c_master s_axis_cmd_address
m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write, m_axis_cmd_write_multiple, m_axis_cmd_stop  out  1 each  command flags
m_axis_cmd_valid  out  1 / m_axis_cmd_ready  in  1  command handshake
m_axis_data_tdata  out  8 / m_axis_data_tvalid  out  1 / m_axis_data_tready  in  1 / m_axis_data_tlast  out  1  write data to master
s_axis_data_tdata  in  8 / s_axis_data_tvalid  in  1 / s_axis_data_tready  out  1 / s_axis_data_tlast  in  1  read data from master
i2c_busy  in  1  i2c_master busy
i2c_missed_ack  in  1  i2c_master missed_ack

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, err flag 0.
- Request latch:
  - In IDLE, req_ready=1. On handshake, latch the request fields and clear err and the busy_seen flag.
  - req_ready=0 in every other state.
- FSM states: IDLE -> CMD_WR -> DATA -> {WAIT_IDLE | CMD_RD} ; CMD_RD -> RD_DATA -> WAIT_IDLE -> RESP -> IDLE.
- CMD_WR:
  - Assert cmd_valid with write_multiple=1, address=latched dev addr, stop=!req_read, all other flags 0.
  - Hold every field stable until cmd_ready. Then go to DATA.
- DATA:
  - Present reg addr bytes MSB first. For writes, follow them with wdata.
  - tlast=1 on the final byte: byte REG_ADDR_BYTES-1 for reads, byte REG_ADDR_BYTES for writes.
  - One byte per tvalid&&tready; tdata and tlast hold stable while stalled.
  - After the final handshake: writes go to WAIT_IDLE, reads go to CMD_RD.
- CMD_RD:
  - cmd_valid with start=1, read=1, stop=1, other flags 0.
  - On handshake go to RD_DATA.
- RD_DATA:
  - s_axis_data_tready=1.
  - On the first s_axis handshake, capture tdata into rsp_rdata and go to WAIT_IDLE.
  - Extra beats are not expected; s_axis tready=0 outside RD_DATA.
- WAIT_IDLE:
  - Set busy_seen once i2c_busy=1 has been seen at any time since the first cmd handshake.
  - Exit to RESP when busy_seen && !i2c_busy.
- Error capture: in any non-IDLE state, i2c_missed_ack=1 sets the sticky err flag. The sequence still completes normally, because i2c_master itself aborts and drains.
- RESP: rsp_valid=1 for one cycle with rsp_err=err, then IDLE. rsp_rdata is held until the next request is accepted.
- Earliest next acceptance: req_ready is reasserted the cycle after rsp_valid.
- Mid-operation reset: forces IDLE immediately, deasserts all valids, and produces no response.

Optional Feature:
I2C_REG_TIMEOUT_EN:
- Defined: a cycle counter clears on request accept and increments every non-IDLE cycle. When it reaches TIMEOUT_CYCLES, deassert all valids, set err, go to RESP (rsp_rdata=0).
- Undefined: no counter, and no path to RESP other than normal completion.

Decomposition:
- Package i2c_reg_pkg holds:
  - the FSM state enum;
  - a byte-count width constant;
  - an IDLE_RDATA=8'h00 constant.
- No sub-module is natural; the byte serializer and the watchdog stay inline.

Test Plan:
- Write, REG_ADDR_BYTES=1: dev 7'h5a, reg 8'h10, data 8'hA5, slave ACKs.
  - Cmd seen: write_multiple=1, stop=1.
  - Data bytes: 8'h10, then 8'hA5 with tlast.
  - Response: rsp_valid with rsp_err=0, rsp_rdata=0.
- Read, REG_ADDR_BYTES=2: reg 16'h0123, slave returns 8'h3C.
  - Cmds: write_multiple with stop=0, bytes 8'h01, 8'h23 (tlast); then read with start=1, stop=1.
  - Response: rsp_rdata=8'h3C, rsp_err=0.
- Backpressure: hold m_axis_cmd_ready=0 and m_axis_data_tready=0 for 7 cycles each. Fields must stay stable while stalled, and the result must equal the unstalled run.
- NACK: slave absent, so i2c_missed_ack pulses. Required: rsp_valid with rsp_err=1, and req_ready returns to 1 afterwards.
- Reset mid-DATA: pulse rst during the second data byte. Required: all valids 0 the next cycle, no rsp_valid, and the next request completes normally.
- With I2C_REG_TIMEOUT_EN and TIMEOUT_CYCLES=100: tie m_axis_cmd_ready=0. Required: rsp_err=1 and rsp_valid exactly 101 cycles after request accept.
